// File: rtl/pong_pkg.sv
// pong_pkg: shared TinyPong state encoding, default geometry and centre positions
package pong_pkg;
  typedef enum logic [2:0] {
    S_SERVE,
    S_WAIT,
    S_PADDLE,
    S_BALL,
    S_CHECK,
    S_OVER
  } state_t;
  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_BALL_SIZE    = 8;
  localparam int DEF_PADDLE_X     = 16;
  localparam int DEF_PADDLE_W     = 8;
  localparam int DEF_PADDLE_H     = 64;
  localparam int DEF_PADDLE_STEP  = 4;
  localparam int DEF_BALL_SPEED   = 2;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam logic [9:0] CENTRE_X  = 10'(DEF_H_ACTIVE / 2 - DEF_BALL_SIZE / 2);
  localparam logic [9:0] CENTRE_Y  = 10'(DEF_V_ACTIVE / 2 - DEF_BALL_SIZE / 2);
  localparam logic [9:0] PADDLE_Y0 = 10'((DEF_V_ACTIVE - DEF_PADDLE_H) / 2);
endpackage

// File: rtl/pong_btn_sync.sv
// pong_btn_sync: two-flop synchronizer for the raw up/down buttons
module pong_btn_sync (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_btn,
  output logic [1:0] o_btn
);
  logic [1:0] r_meta;
  logic [1:0] r_sync;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
    end
  end
  assign o_btn = r_sync;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-synchronous TinyPong paddle/ball physics, scoring and lives
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PADDLE_X     = DEF_PADDLE_X,
  parameter int PADDLE_W     = DEF_PADDLE_W,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int PADDLE_STEP  = DEF_PADDLE_STEP,
  parameter int BALL_SPEED   = DEF_BALL_SPEED,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_start,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic [9:0] o_paddle_y,
  output logic [7:0] o_hits,
  output logic [1:0] o_lives,
  output logic       o_game_over,
  output logic       o_busy,
  output logic       o_overrun
);
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [10:0] C_H    = 11'(H_ACTIVE);
  localparam logic [10:0] C_V    = 11'(V_ACTIVE);
  localparam logic [10:0] C_BS   = 11'(BALL_SIZE);
  localparam logic [10:0] C_SPD  = 11'(BALL_SPEED);
  localparam logic [10:0] C_STEP = 11'(PADDLE_STEP);
  localparam logic [10:0] C_PH   = 11'(PADDLE_H);
  localparam logic [10:0] C_PXR  = 11'(PADDLE_X + PADDLE_W);
  localparam logic [10:0] C_PMAX = 11'(V_ACTIVE - PADDLE_H);
  localparam logic [9:0]  C_X0   = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  C_Y0   = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  C_P0   = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0]  C_XMAX = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  C_YMAX = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [CW-1:0] C_SERVE = CW'(SERVE_FRAMES);
  state_t        r_state;
  logic [9:0]    r_ball_x, r_ball_y, r_paddle_y, r_nx, r_ny;
  logic          r_dx, r_dy, r_hit_pend, r_miss_pend;
  logic [7:0]    r_hits;
  logic [1:0]    r_lives;
  logic [CW-1:0] r_serve_cnt;
  logic          r_busy, r_game_over, r_overrun;
  logic [1:0]    w_btn;
  logic          w_up, w_down, w_both;
  logic [10:0]   w_x, w_y, w_py, w_xp, w_xm, w_yp, w_ym, w_pu, w_pd;
  logic          w_rwall, w_bwall, w_twall, w_hit, w_miss;
  logic [9:0]    w_paddle_nxt, w_nx, w_ny;
  pong_btn_sync u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_btn  ({i_btn_down, i_btn_up}),
    .o_btn  (w_btn)
  );
  assign w_up   = w_btn[0] & ~w_btn[1];
  assign w_down = w_btn[1] & ~w_btn[0];
  assign w_both = w_btn[0] & w_btn[1];
  // 11-bit working values so that x-SPEED and y-SPEED expose a borrow bit
  always_comb begin
    w_x  = {1'b0, r_ball_x};
    w_y  = {1'b0, r_ball_y};
    w_py = {1'b0, r_paddle_y};
    w_pu = w_py - C_STEP;
    w_pd = w_py + C_STEP;
    w_paddle_nxt = w_up ? (w_pu[10] ? 10'd0 : w_pu[9:0]) :
                   w_down ? ((w_pd > C_PMAX) ? C_PMAX[9:0] : w_pd[9:0]) : r_paddle_y;
    w_xp = w_x + C_SPD;
    w_xm = w_x - C_SPD;
    w_yp = w_y + C_SPD;
    w_ym = w_y - C_SPD;
    w_rwall = (w_xp + C_BS) >= C_H;
    w_bwall = (w_yp + C_BS) >= C_V;
    w_twall = w_ym[10] | (w_ym == 11'd0);
    w_hit = ~r_dx & (w_x >= C_PXR) & (w_xm < C_PXR) & ((w_y + C_BS) > w_py) & (w_y < (w_py + C_PH));
    w_miss = ~r_dx & ~w_hit & w_xm[10];
    w_nx = r_dx ? (w_rwall ? C_XMAX : w_xp[9:0]) : (w_hit ? C_PXR[9:0] : w_xm[9:0]);
    w_ny = r_dy ? (w_bwall ? C_YMAX : w_yp[9:0]) : (w_twall ? 10'd0 : w_ym[9:0]);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_SERVE;
      r_ball_x    <= C_X0;
      r_ball_y    <= C_Y0;
      r_paddle_y  <= C_P0;
      r_nx        <= C_X0;
      r_ny        <= C_Y0;
      r_dx        <= 1'b1;
      r_dy        <= 1'b1;
      r_hit_pend  <= 1'b0;
      r_miss_pend <= 1'b0;
      r_hits      <= 8'd0;
      r_lives     <= 2'd3;
      r_serve_cnt <= C_SERVE;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (r_state == S_OVER && i_frame_start && w_both) begin
      r_state     <= S_SERVE;
      r_ball_x    <= C_X0;
      r_ball_y    <= C_Y0;
      r_paddle_y  <= C_P0;
      r_nx        <= C_X0;
      r_ny        <= C_Y0;
      r_dx        <= 1'b1;
      r_dy        <= 1'b1;
      r_hit_pend  <= 1'b0;
      r_miss_pend <= 1'b0;
      r_hits      <= 8'd0;
      r_lives     <= 2'd3;
      r_serve_cnt <= C_SERVE;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (i_frame_start && r_busy) r_overrun <= 1'b1;
      case (r_state)
        S_SERVE: if (i_frame_start) begin
          r_paddle_y  <= w_paddle_nxt;
          r_serve_cnt <= r_serve_cnt - CW'(1);
          if (r_serve_cnt == CW'(1)) r_state <= S_WAIT;
        end
        S_WAIT: if (i_frame_start) begin
          r_state <= S_PADDLE;
          r_busy  <= 1'b1;
        end
        S_PADDLE: begin
          r_paddle_y <= w_paddle_nxt;
          r_state    <= S_BALL;
        end
        S_BALL: begin
          r_nx        <= w_nx;
          r_ny        <= w_ny;
          r_dx        <= r_dx ? ~w_rwall : w_hit;
          r_dy        <= r_dy ? ~w_bwall : w_twall;
          r_hit_pend  <= w_hit;
          r_miss_pend <= w_miss;
          r_state     <= S_CHECK;
        end
        S_CHECK: begin
          r_busy <= 1'b0;
          if (r_miss_pend) begin
            r_lives <= r_lives - 2'd1;
            if (r_lives == 2'd1) begin
              r_state     <= S_OVER;
              r_game_over <= 1'b1;
            end else begin
              r_ball_x    <= C_X0;
              r_ball_y    <= C_Y0;
              r_dx        <= 1'b1;
              r_serve_cnt <= C_SERVE;
              r_state     <= S_SERVE;
            end
          end else begin
            r_ball_x <= r_nx;
            r_ball_y <= r_ny;
            if (r_hit_pend && r_hits != 8'hFF) r_hits <= r_hits + 8'd1;
            r_state <= S_WAIT;
          end
        end
        S_OVER: r_state <= S_OVER;
        default: r_state <= S_SERVE;
      endcase
    end
  end
  assign o_ball_x    = r_ball_x;
  assign o_ball_y    = r_ball_y;
  assign o_paddle_y  = r_paddle_y;
  assign o_hits      = r_hits;
  assign o_lives     = r_lives;
  assign o_game_over = r_game_over;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed checks of serve, paddle clamp, wall bounce, paddle hit, misses, restart
module tb_pong_game_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       fs;
  logic       up;
  logic       dn;
  logic [9:0] ball_x, ball_y, paddle_y;
  logic [7:0] hits;
  logic [1:0] lives;
  logic       game_over, busy, overrun;
  int         n_chk = 0;
  int         n_fail = 0;
  pong_game_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_start(fs),
    .i_btn_up     (up),
    .i_btn_down   (dn),
    .o_ball_x     (ball_x),
    .o_ball_y     (ball_y),
    .o_paddle_y   (paddle_y),
    .o_hits       (hits),
    .o_lives      (lives),
    .o_game_over  (game_over),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );
  always #20 clk = ~clk;
  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask
  task automatic set_btn(input logic u, input logic d);
    up = u;
    dn = d;
    repeat (3) @(negedge clk);
  endtask
  task automatic frame();
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    repeat (6) @(negedge clk);
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask
  initial begin
    rst_n = 1'b0;
    fs = 1'b0;
    up = 1'b0;
    dn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ball_x", ball_x, 316);
    check("rst_ball_y", ball_y, 236);
    check("rst_paddle", paddle_y, 208);
    check("rst_hits", hits, 0);
    check("rst_lives", lives, 3);
    check("rst_over", game_over, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);
    set_btn(1'b1, 1'b0);
    frame();
    check("serve_pad_f1", paddle_y, 204);
    check("serve_ball_f1", ball_x, 316);
    frames(50);
    check("pad_f51", paddle_y, 4);
    frame();
    check("pad_f52_clamp", paddle_y, 0);
    frames(7);
    check("pad_f59", paddle_y, 0);
    check("serve_ball_f59", ball_x, 316);
    frame();
    check("serve_ball_x_f60", ball_x, 316);
    check("serve_ball_y_f60", ball_y, 236);
    check("serve_busy", busy, 0);
    set_btn(1'b0, 1'b1);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    check("lat_busy_n1", busy, 1);
    check("lat_pad_n1", paddle_y, 0);
    @(negedge clk);
    check("lat_pad_n2", paddle_y, 4);
    check("lat_ball_n2", ball_x, 316);
    @(negedge clk);
    check("lat_ball_n3", ball_x, 316);
    check("lat_busy_n3", busy, 1);
    @(negedge clk);
    check("lat_ball_x_n4", ball_x, 318);
    check("lat_ball_y_n4", ball_y, 238);
    check("lat_busy_n4", busy, 0);
    check("lat_hits", hits, 0);
    repeat (3) @(negedge clk);
    set_btn(1'b1, 1'b1);
    check("pre_overrun", overrun, 0);
    fs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    fs = 1'b0;
    repeat (6) @(negedge clk);
    check("overrun_set", overrun, 1);
    check("overrun_ball_x", ball_x, 320);
    check("overrun_ball_y", ball_y, 240);
    check("both_pad", paddle_y, 4);
    frame();
    check("k3_ball_x", ball_x, 322);
    check("k3_ball_y", ball_y, 242);
    check("k3_both_pad", paddle_y, 4);
    set_btn(1'b0, 1'b1);
    frames(45);
    check("pad_down_184", paddle_y, 184);
    set_btn(1'b0, 1'b0);
    frames(70);
    check("k118_x", ball_x, 552);
    check("k118_y_bottom", ball_y, 472);
    frame();
    check("k119_y", ball_y, 470);
    frames(39);
    check("k158_x_right", ball_x, 632);
    check("k158_y", ball_y, 392);
    frame();
    check("k159_x", ball_x, 630);
    frames(302);
    check("k461_x", ball_x, 26);
    frame();
    check("k462_x", ball_x, 24);
    check("k462_hits", hits, 0);
    frame();
    check("hit_x", ball_x, 24);
    check("hit_hits", hits, 1);
    frame();
    check("hit_dx_right", ball_x, 26);
    check("hit_hits_hold", hits, 1);
    set_btn(1'b1, 1'b0);
    frames(50);
    check("pad_top", paddle_y, 0);
    set_btn(1'b0, 1'b0);
    for (int i = 0; i < 800 && lives == 2'd3; i++) frame();
    check("miss1_lives", lives, 2);
    check("miss1_x", ball_x, 316);
    check("miss1_y", ball_y, 236);
    check("miss1_hits", hits, 1);
    check("miss1_over", game_over, 0);
    frames(60);
    check("miss1_serve_hold", ball_x, 316);
    frame();
    check("miss1_served", ball_x, 318);
    for (int i = 0; i < 800 && lives == 2'd2; i++) frame();
    check("miss2_lives", lives, 1);
    check("miss2_x", ball_x, 316);
    for (int i = 0; i < 800 && lives == 2'd1; i++) frame();
    check("miss3_lives", lives, 0);
    check("over_flag", game_over, 1);
    check("over_x", ball_x, 0);
    check("over_busy", busy, 0);
    set_btn(1'b0, 1'b1);
    frame();
    check("frozen_pad", paddle_y, 0);
    check("frozen_x", ball_x, 0);
    check("frozen_over", game_over, 1);
    check("frozen_overrun", overrun, 1);
    set_btn(1'b1, 1'b1);
    frame();
    check("restart_x", ball_x, 316);
    check("restart_y", ball_y, 236);
    check("restart_pad", paddle_y, 208);
    check("restart_lives", lives, 3);
    check("restart_hits", hits, 0);
    check("restart_over", game_over, 0);
    check("restart_overrun", overrun, 0);
    set_btn(1'b1, 1'b0);
    frames(60);
    check("abort_pre_pad", paddle_y, 0);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    check("abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy_clr", busy, 0);
    check("abort_pad", paddle_y, 208);
    check("abort_x", ball_x, 316);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Frame-synchronous game controller for the TinyPong design. It owns the ball, paddle, direction, hit-count and lives registers. Once per video frame, on the vertical-blank start pulse from the VGA timing block, it sequences one physics update: paddle move, ball move, then collision and scoring. The renderer reads position outputs that are guaranteed stable for the whole active frame.

## Interface
- H_ACTIVE, 640: visible width in pixels
- V_ACTIVE, 480: visible height in pixels
- BALL_SIZE, 8: ball edge length in pixels
- PADDLE_X, 16: paddle left edge x
- PADDLE_W, 8: paddle width
- PADDLE_H, 64: paddle height
- PADDLE_STEP, 4: paddle pixels per frame
- BALL_SPEED, 2: ball pixels per frame, per axis
- SERVE_FRAMES, 60: frames the ball is held at centre before a serve
- clk  in  1  25 MHz pixel clock
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- btn_up  in  1  raw up button (ui_in[0]), asynchronous
- btn_down  in  1  raw down button (ui_in[1]), asynchronous
- ball_x  out  10  ball left edge
- ball_y  out  10  ball top edge
- paddle_y  out  10  paddle top edge
- hits  out  8  paddle hits; saturates at 255
- lives  out  2  remaining lives
- game_over  out  1  high in state OVER
- busy  out  1  high while an update sequence is in progress
- overrun  out  1  sticky; set when frame_start arrives while busy; cleared by reset or restart

## Operation
- Buttons pass through a 2-FF synchronizer. up = up_s & ~down_s; down = down_s & ~up_s. Both pressed or neither pressed: no paddle move.
- States: SERVE, WAIT, PADDLE, BALL, CHECK, OVER.
- SERVE:
  - Ball is held at (H_ACTIVE/2-BALL_SIZE/2, V_ACTIVE/2-BALL_SIZE/2) = (316, 236).
  - The paddle still updates on each frame_start.
  - The serve counter decrements on each frame_start; the frame_start on which it reaches 0 moves the state to WAIT.
- WAIT: on frame_start → PADDLE.
- PADDLE:
  - up: paddle_y = max(paddle_y-STEP, 0).
  - down: paddle_y = min(paddle_y+STEP, V_ACTIVE-PADDLE_H).
  - → BALL.
- BALL, computing next x and y in working registers (bits 11 wide to avoid underflow):
  - Moving right: nx = x+SPEED. If nx+BALL_SIZE ≥ H_ACTIVE, nx = H_ACTIVE-BALL_SIZE and dx flips to left.
  - Moving left, paddle hit: if x ≥ PADDLE_X+PADDLE_W, and x-SPEED < PADDLE_X+PADDLE_W, and y+BALL_SIZE > paddle_y, and y < paddle_y+PADDLE_H, then nx = PADDLE_X+PADDLE_W, dx flips to right, and hit_pending is set.
  - Moving left, no hit, x < SPEED: miss_pending is set.
  - Moving left, otherwise: nx = x-SPEED.
  - Y uses the same rule against 0 and V_ACTIVE-BALL_SIZE, with reflection at both walls.
- CHECK:
  - miss_pending: lives decrements. If lives becomes 0 → OVER. Otherwise the ball recentres, dx = right, the serve counter reloads with SERVE_FRAMES, and the state goes to SERVE.
  - Otherwise: ball_x/ball_y are committed from nx/ny, hits increments if hit_pending (saturating), and the state goes to WAIT.
- OVER:
  - All positions are frozen.
  - On a frame_start with both synchronized buttons high, every register returns to its reset value (state SERVE).

## Timing
- Reset values:
  - ball = (316, 236); paddle_y = (V_ACTIVE-PADDLE_H)/2 = 208.
  - dx = right, dy = down.
  - hits = 0, lives = 3, serve counter = SERVE_FRAMES.
  - state SERVE; busy = 0, overrun = 0, game_over = 0.
- Button latency is 2 cycles (synchronizer). A button pulse shorter than 2 cycles may be lost.
- Update latency: frame_start in cycle N → PADDLE in N+1, BALL in N+2, CHECK in N+3. New ball values are visible in N+4. paddle_y is visible in N+2.
- busy is high in PADDLE, BALL and CHECK. A frame_start while busy is dropped and sets overrun.
- Outputs change only in the PADDLE and CHECK cycles, or on a restart. All outputs are registered.
- A reset assertion mid-sequence aborts immediately to the reset values. No partial commit.

## Structure
- Package pong_pkg holds:
  - the state enum;
  - the default geometry constants (H_ACTIVE, V_ACTIVE, BALL_SIZE, paddle geometry);
  - the centre-position constants.
  The top-level pong module and the renderer share this package.
- One sub-module, pong_btn_sync: a 2-bit, 2-FF synchronizer with asynchronous active-low reset. Instantiated once.
- The FSM, position arithmetic and scoring live in pong_game_ctrl. Target size is roughly 200 lines.

## Test plan
- Reset, then 60 frame_start pulses with no buttons → ball stays at (316, 236) until the 60th pulse. On the next frame the ball is at (318, 238) and hits = 0.
- btn_up held for 60 frames starting from paddle_y = 208 → paddle_y decreases by 4 per frame and clamps at 0 from frame 52 on. Both buttons held → paddle_y is unchanged.
- Ball moving left at x = 24, y = 200, paddle_y = 180 → ball_x = 24 after the update, dx = right, hits = 1.
- Ball moving left at x = 1, with the paddle clear of the ball → lives goes 3→2, ball recentres at (316, 236), state is SERVE.
- Third miss → game_over = 1 and positions are frozen. A frame_start with both buttons high → lives = 3, hits = 0, game_over = 0.
- frame_start pulses in consecutive cycles → the second pulse is ignored, overrun = 1, and exactly one update is applied.
